inner_loop_chunked: RTL and testbench
=====================================

Name: inner_loop_chunked

Overview:
- Parametrised, multi-cycle successor to the single-digit inner-loop multiplier.
- Computes a multi-precision operand A times one digit Bi, CHUNK_W bits of A per cycle, into a carry-save accumulator {r0, r1}.
- Three accumulate modes: clear, accumulate, and shift-accumulate. Shift-accumulate is the Montgomery digit step: the old sum is divided by 2^D_W before the new product is added.
- Sits in the outer modular-multiply loop, which issues one start per digit of B.

Parameters:
- A_W, 3074, width of multiplicand a.
- D_W, 54, width of digit bi.
- CHUNK_W, 512, bits of a consumed per cycle; must satisfy 1 <= CHUNK_W <= A_W.
- Derived (localparam): NCHUNK = ceil(A_W/CHUNK_W); R_W = A_W + D_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- mode, input, 2, 00 clear / 01 accumulate / 10 shift-accumulate / 11 treated as 01.
- a, input, A_W, multiplicand; latched at accepted start.
- bi, input, D_W, digit; latched at accepted start.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse when the result is final.
- r0, output, R_W, carry-save sum word.
- r1, output, R_W, carry-save carry word.

Behaviour:
- Reset (async, any time, including mid-run):
  - r0 = r1 = 0, busy = 0, done = 0, state = IDLE.
  - Latched operands are cleared.
  - No done pulse is produced for an aborted run.
- Architected result is S = (r0 + r1) mod 2^R_W. Individual r0/r1 bit patterns are implementation-defined; verification compares S only.
- States:
  - IDLE: if start, latch a (zero-extended to NCHUNK*CHUNK_W), bi and mode; apply the mode pre-step to {r0, r1}; cnt = 0; go to RUN.
  - RUN: each edge adds pp_k = (a chunk k) * bi, shifted left by k*CHUNK_W, into {r0, r1} with a 3:2 carry-save add truncated to R_W. Then cnt++. When cnt == NCHUNK-1, go to DONE.
  - DONE: done = 1 for this cycle only; next edge goes to IDLE.
- Mode pre-step, same edge as start acceptance:
  - 00: r0 = r1 = 0.
  - 01: {r0, r1} unchanged.
  - 10: S becomes floor(S / 2^D_W) exactly. r0 and r1 are shifted right by D_W and the carry-out of r0[D_W-1:0] + r1[D_W-1:0] is injected as a +1. Shifting the two words independently is non-compliant.
- Latency:
  - start is sampled at edge T0.
  - Chunks are processed at edges T1..T_NCHUNK.
  - done is high for the cycle following edge T_NCHUNK.
  - IDLE is re-entered at T_NCHUNK+1, so the earliest next accepted start is at T_NCHUNK+2.
  - Throughput: one digit per NCHUNK+2 cycles.
- start while busy = 1 (RUN or DONE) is ignored: no relatch, no effect on the result.
- a, bi and mode may change freely after acceptance.
- r0/r1 are valid to read when done = 1 or in IDLE. They hold their value in IDLE indefinitely.
- Overflow wraps modulo 2^R_W silently.
- NCHUNK == 1 is legal: exactly one RUN cycle.

Decomposition:
- Shared package inner_loop_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode encodings (MODE_CLR, MODE_ACC, MODE_SHACC);
  - a ceil-div function used for NCHUNK.
- One sub-module, csa_3to2 #(W): purely combinational, computing sum = x^y^z and carry = maj(x,y,z) << 1, truncated to W.
- Top level holds the FSM, chunk counter/mux, chunk-by-digit multiplier and shift-pre-step logic.

Test Plan (A_W=16, D_W=8, CHUNK_W=4, so NCHUNK=4 and R_W=24, unless noted):
1. Assert rst mid-cycle with no clock edge -> r0 = r1 = 0, busy = 0, done = 0 immediately. Release, idle 3 cycles -> outputs unchanged.
2. mode=00, a=0xFFFF, bi=0xFF, start at T0 -> busy from T0 to T_NCHUNK+1, done exactly in the cycle after T4, S = 0xFEFF01.
3. Then mode=01, a=0x0001, bi=0x02 -> S = 0xFEFF03. Then mode=01, a=0xFFFF, bi=0xFF -> S = 0xFDFE04 (wrap mod 2^24).
4. From S = 0xFEFF03, mode=10, a=0x0010, bi=0x01 -> S = 0x00FF0F. Also preload a state where r0 and r1 low bytes sum with a carry (e.g. run mode=00 with a=0x0081, bi=0x01 and then mode=01 with a=0x007F, bi=0x01), then mode=10, a=0, bi=0 -> S = 0x000001.
5. Pulse start with different operands during RUN and during the done cycle -> result unchanged, exactly one done. Assert rst during RUN cnt=2 -> all outputs zero, no done, next start runs normally.
6. Default parameters: 200 random {a, bi, mode} sequences, back-to-back starts at the earliest legal edge -> S matches a golden big-integer model after every done. Repeat with CHUNK_W=A_W (NCHUNK=1).

Source files
------------

// File: rtl/inner_loop_pkg.sv
// Shared types and helpers for the chunked inner-loop multiplier.
package inner_loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_CLR   = 2'b00;
  localparam logic [1:0] MODE_ACC   = 2'b01;
  localparam logic [1:0] MODE_SHACC = 2'b10;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/inner_loop_chunked_csa.sv
// 3:2 carry-save compressor; the carry word is pre-shifted and truncated to W bits.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = x ^ y ^ z;
  assign carry = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/inner_loop_chunked.sv
// Multi-cycle A * Bi into a carry-save accumulator, CHUNK_W bits of A per cycle,
// with clear / accumulate / shift-accumulate (Montgomery digit step) modes.
module inner_loop_chunked
  import inner_loop_pkg::*;
#(
  parameter int A_W     = 3074,
  parameter int D_W     = 54,
  parameter int CHUNK_W = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [A_W-1:0]       a,
  input  logic [D_W-1:0]       bi,
  output logic                 busy,
  output logic                 done,
  output logic [A_W+D_W-1:0]   r0,
  output logic [A_W+D_W-1:0]   r1
);

  localparam int NCHUNK = ceil_div(A_W, CHUNK_W);
  localparam int R_W    = A_W + D_W;
  localparam int AX_W   = NCHUNK * CHUNK_W;
  localparam int P_W    = CHUNK_W + D_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [AX_W-1:0]   a_q;
  logic [D_W-1:0]    bi_q;
  logic [31:0]       shamt;
  logic [CHUNK_W-1:0] chunk;
  logic [P_W-1:0]    pp;
  logic [R_W-1:0]    pp_ext, csa_sum, csa_carry, r0_pre, r1_pre;
  logic [D_W:0]      lo_sum;
  logic [A_W-1:0]    hi_sum;
  logic              accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Chunk k of A times the digit, placed at bit k*CHUNK_W of the accumulator.
  assign shamt  = 32'(cnt) * 32'(CHUNK_W);
  assign chunk  = CHUNK_W'(a_q >> shamt);
  assign pp     = P_W'(chunk) * P_W'(bi_q);
  assign pp_ext = R_W'(pp) << shamt;

  csa_3to2 #(.W(R_W)) u_csa (
    .x     (r0),
    .y     (r1),
    .z     (pp_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Exact floor(S / 2^D_W): the carry out of the dropped low digits must be kept,
  // and the result is collapsed into r0 so the top D_W bits of S come out zero.
  assign lo_sum = {1'b0, r0[D_W-1:0]} + {1'b0, r1[D_W-1:0]};
  assign hi_sum = r0[R_W-1:D_W] + r1[R_W-1:D_W] + A_W'(lo_sum >> D_W);

  always_comb begin
    r0_pre = r0;
    r1_pre = r1;
    case (mode)
      MODE_CLR: begin
        r0_pre = '0;
        r1_pre = '0;
      end
      MODE_SHACC: begin
        r0_pre = R_W'(hi_sum);
        r1_pre = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0   <= '0;
      r1   <= '0;
      a_q  <= '0;
      bi_q <= '0;
      cnt  <= '0;
    end else if (accept) begin
      a_q  <= AX_W'(a);
      bi_q <= bi;
      r0   <= r0_pre;
      r1   <= r1_pre;
      cnt  <= '0;
    end else if (state == RUN) begin
      r0 <= csa_sum;
      r1 <= csa_carry;
      if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inner_loop_chunked.sv
// Scoreboard bench: small directed config plus random runs on the default and single-chunk configs.
module tb_inner_loop_chunked;

  localparam int SA = 16, SD = 8, SC = 4, SR = 24, SN = 4;
  localparam int BA = 3074, BD = 54, BR = 3128, BN = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          s_start;
  logic [1:0]    s_mode;
  logic [SA-1:0] s_a;
  logic [SD-1:0] s_bi;
  logic          s_busy, s_done;
  logic [SR-1:0] s_r0, s_r1, s_sum;

  logic [1:0]    g_mode;
  logic [BA-1:0] g_a;
  logic [BD-1:0] g_bi;
  logic          b_start, c_start;
  logic          b_busy, b_done, c_busy, c_done;
  logic [BR-1:0] b_r0, b_r1, c_r0, c_r1, b_sum, c_sum;

  assign s_sum = s_r0 + s_r1;
  assign b_sum = b_r0 + b_r1;
  assign c_sum = c_r0 + c_r1;

  inner_loop_chunked #(.A_W(SA), .D_W(SD), .CHUNK_W(SC)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .bi(s_bi),
    .busy(s_busy), .done(s_done), .r0(s_r0), .r1(s_r1));

  inner_loop_chunked #(.A_W(BA), .D_W(BD), .CHUNK_W(512)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .mode(g_mode), .a(g_a), .bi(g_bi),
    .busy(b_busy), .done(b_done), .r0(b_r0), .r1(b_r1));

  inner_loop_chunked #(.A_W(BA), .D_W(BD), .CHUNK_W(BA)) u_one (
    .clk(clk), .rst(rst), .start(c_start), .mode(g_mode), .a(g_a), .bi(g_bi),
    .busy(c_busy), .done(c_done), .r0(c_r0), .r1(c_r1));

  int compareCount = 0;
  int failCount = 0;
  logic [BR-1:0] expQ[$];
  logic [BR-1:0] modelS;

  // Golden model: plain big-integer arithmetic modulo 2^rw.
  function automatic logic [BR-1:0] modelNext(input logic [BR-1:0] s, input logic [1:0] m,
                                               input logic [BR-1:0] av, input logic [BR-1:0] bv,
                                               input int rw, input int dw);
    logic [BR-1:0] mask, pre;
    mask = '1;
    mask = mask >> (BR - rw);
    case (m)
      2'b00:   pre = '0;
      2'b10:   pre = s >> dw;
      default: pre = s;
    endcase
    return (pre + av * bv) & mask;
  endfunction

  task automatic checkOutput(input string tag, input logic [BR-1:0] observed,
                             input logic [BR-1:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed[127:0], expected[127:0]);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [SA-1:0] av, input logic [SD-1:0] bv);
    s_mode  = m;
    s_a     = av;
    s_bi    = bv;
    s_start = 1'b1;
    modelS  = modelNext(modelS, m, BR'(av), BR'(bv), SR, SD);
    expQ.push_back(modelS);
  endtask

  // One small-config digit, optionally poking start during RUN and during DONE.
  task automatic runSmall(input logic [1:0] m, input logic [SA-1:0] av, input logic [SD-1:0] bv,
                          input bit poke);
    int lat;
    logic [BR-1:0] e;
    applyStimulus(m, av, bv);
    @(negedge clk);
    s_start = 1'b0;
    lat = 1;
    while (s_done !== 1'b1 && lat < 20) begin
      checkOutput("busy_run", BR'(s_busy), BR'(1));
      if (poke && lat == 2) begin
        s_start = 1'b1; s_a = 16'h1234; s_bi = 8'h56; s_mode = 2'b00;
      end
      @(negedge clk);
      s_start = 1'b0;
      lat++;
    end
    checkOutput("done_latency", BR'(lat), BR'(SN + 1));
    e = expQ.pop_front();
    checkOutput("small_result", BR'(s_sum), e);
    checkOutput("busy_in_done", BR'(s_busy), BR'(1));
    if (poke) begin
      s_start = 1'b1; s_a = 16'hBEEF; s_bi = 8'h77; s_mode = 2'b10;
    end
    @(negedge clk);
    s_start = 1'b0;
    checkOutput("done_one_cycle", BR'(s_done), BR'(0));
    checkOutput("idle_after_done", BR'(s_busy), BR'(0));
    checkOutput("hold_in_idle", BR'(s_sum), e);
  endtask

  task automatic newBigOperands(input int n);
    logic [3103:0] t;
    logic [63:0] d;
    for (int w = 0; w < 97; w++) t[w*32 +: 32] = $urandom();
    d = {$urandom(), $urandom()};
    g_a    = t[BA-1:0];
    g_bi   = d[BD-1:0];
    g_mode = 2'($urandom_range(3, 0));
    if (n % 50 == 1) begin g_a = '1; g_bi = '1; end
    if (n % 50 == 2) g_a = '0;
    modelS = modelNext(modelS, g_mode, BR'(g_a), BR'(g_bi), BR, BD);
    expQ.push_back(modelS);
  endtask

  // 200 back-to-back digits with start held high; sel=1 selects the single-chunk instance.
  task automatic runBig(input bit sel);
    int lat, nch;
    logic [BR-1:0] e;
    nch = sel ? 1 : BN;
    modelS = '0;
    newBigOperands(0);
    if (sel) c_start = 1'b1; else b_start = 1'b1;
    for (int n = 0; n < 200; n++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!(sel ? c_done : b_done) && lat < 40);
      checkOutput(sel ? "one_latency" : "big_latency", BR'(lat), BR'((n == 0) ? nch + 1 : nch + 2));
      e = expQ.pop_front();
      checkOutput(sel ? "one_result" : "big_result", sel ? c_sum : b_sum, e);
      if (n < 199) newBigOperands(n + 1);
      else begin b_start = 1'b0; c_start = 1'b0; end
    end
    @(negedge clk);
    checkOutput(sel ? "one_idle" : "big_idle", BR'(sel ? c_busy : b_busy), BR'(0));
  endtask

  initial begin
    int dones;
    s_start = 1'b0; s_mode = '0; s_a = '0; s_bi = '0;
    b_start = 1'b0; c_start = 1'b0; g_mode = '0; g_a = '0; g_bi = '0;
    modelS = '0;

    // Async reset between clock edges takes effect immediately.
    #7 rst = 1'b1;
    #1;
    checkOutput("reset_r0", BR'(s_r0), BR'(0));
    checkOutput("reset_r1", BR'(s_r1), BR'(0));
    checkOutput("reset_busy", BR'(s_busy), BR'(0));
    checkOutput("reset_done", BR'(s_done), BR'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_r0", BR'(s_r0), BR'(0));
    checkOutput("idle_r1", BR'(s_r1), BR'(0));
    checkOutput("idle_busy", BR'(s_busy), BR'(0));
    checkOutput("idle_done", BR'(s_done), BR'(0));

    runSmall(2'b00, 16'hFFFF, 8'hFF, 1'b0);
    checkOutput("clr_ffff_ff", BR'(s_sum), BR'(24'hFEFF01));
    runSmall(2'b01, 16'h0001, 8'h02, 1'b0);
    checkOutput("acc_1_2", BR'(s_sum), BR'(24'hFEFF03));
    runSmall(2'b01, 16'hFFFF, 8'hFF, 1'b0);
    checkOutput("acc_wrap", BR'(s_sum), BR'(24'hFDFE04));

    runSmall(2'b00, 16'hFFFF, 8'hFF, 1'b0);
    runSmall(2'b01, 16'h0001, 8'h02, 1'b0);
    runSmall(2'b10, 16'h0010, 8'h01, 1'b0);
    checkOutput("shacc_basic", BR'(s_sum), BR'(24'h00FF0F));
    runSmall(2'b00, 16'h0081, 8'h01, 1'b0);
    runSmall(2'b01, 16'h007F, 8'h01, 1'b0);
    checkOutput("preload_carry", BR'(s_sum), BR'(24'h000100));
    runSmall(2'b10, 16'h0000, 8'h00, 1'b0);
    checkOutput("shacc_carry_in", BR'(s_sum), BR'(24'h000001));
    runSmall(2'b11, 16'h0003, 8'h03, 1'b0);
    checkOutput("mode11_acc", BR'(s_sum), BR'(24'h00000A));

    runSmall(2'b01, 16'h0102, 8'h03, 1'b1);
    checkOutput("start_while_busy", BR'(s_sum), BR'(24'h000310));

    // Abort a run at cnt=2 with an async reset.
    applyStimulus(2'b00, 16'hABCD, 8'h12);
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_r0", BR'(s_r0), BR'(0));
    checkOutput("abort_r1", BR'(s_r1), BR'(0));
    checkOutput("abort_busy", BR'(s_busy), BR'(0));
    checkOutput("abort_done", BR'(s_done), BR'(0));
    void'(expQ.pop_front());
    modelS = '0;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_done === 1'b1) dones++;
    end
    checkOutput("abort_no_done", BR'(dones), BR'(0));
    runSmall(2'b01, 16'h0005, 8'h07, 1'b0);
    checkOutput("after_abort", BR'(s_sum), BR'(24'h000023));

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    runBig(1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    runBig(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
